// File: rtl/vga_timing_pkg.sv
// Shared definitions for the parametrised VGA timing generator: pattern mode
// encodings, the colour-bar table and reference timing sets.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        MODE_EXT  = 2'd0,
        MODE_BARS = 2'd1,
        MODE_GRID = 2'd2,
        MODE_GRAD = 2'd3
    } vga_mode_e;

    // {R,G,B} on/off per bar; index 0 (white) is the leftmost bar.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t TIMING_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29};
    localparam vga_timing_t TIMING_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};

endpackage

// File: rtl/vga_timing_gen_param_pattern.sv
// Built-in test-pattern source: one register stage from the stage-1 pixel
// coordinates, so the pattern lines up with external frame-buffer data.
module vga_pattern_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 12,
    parameter int GRID     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic [CNT_W-1:0]       x_i,
    input  logic [CNT_W-1:0]       y_i,
    input  vga_mode_e              mode_i,
    input  logic [COLOR_W-1:0]     frame_lsb_i,
    output logic [3*COLOR_W-1:0]   rgb_o,
    output logic                   ext_o
);

    localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'((H_ACTIVE >> 3) - 1);
    localparam logic [CNT_W-1:0] GRID_MASK = CNT_W'(GRID - 1);
    localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(V_ACTIVE - 1);

    logic [2:0]           bar_idx_q, bar_idx_d, bar_cur;
    logic [CNT_W-1:0]     bar_cnt_q, bar_cnt_d, cnt_cur;
    logic [2:0]           bar_on;
    logic                 grid_on;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic                 ext_q, ext_d;

    always_comb begin
        // X == 0 restarts the bar walk at the start of every active line.
        bar_cur   = (x_i == '0) ? 3'd0 : bar_idx_q;
        cnt_cur   = (x_i == '0) ? '0 : bar_cnt_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        if (req_i) begin
            if (cnt_cur == BAR_LAST && bar_cur != 3'd7) begin
                bar_idx_d = bar_cur + 3'd1;
                bar_cnt_d = '0;
            end else begin
                // The last bar absorbs the remainder, so it stops counting.
                bar_idx_d = bar_cur;
                bar_cnt_d = (bar_cur == 3'd7) ? cnt_cur : cnt_cur + 1'b1;
            end
        end

        bar_on  = BAR_TABLE[bar_cur];
        grid_on = ((x_i & GRID_MASK) == '0) || ((y_i & GRID_MASK) == '0) ||
                  (x_i == X_LAST) || (y_i == Y_LAST);

        ext_d = (mode_i == MODE_EXT);
        rgb_d = '0;
        if (req_i) begin
            unique case (mode_i)
                MODE_BARS: rgb_d = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};
                MODE_GRID: rgb_d = {(3*COLOR_W){grid_on}};
                MODE_GRAD: rgb_d = {x_i[COLOR_W-1:0], y_i[COLOR_W-1:0], frame_lsb_i};
                default:   rgb_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
            rgb_q     <= '0;
            ext_q     <= 1'b1;
        end else begin
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
            rgb_q     <= rgb_d;
            ext_q     <= ext_d;
        end
    end

    assign rgb_o = rgb_q;
    assign ext_o = ext_q;

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: counters, sync/DE, pixel requests to an
// external frame buffer and a per-frame selectable built-in test pattern.
module vga_timing_gen_param
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 12,
    parameter int GRID     = 64
) (
    input  logic                 VGA_CLK,
    input  logic                 VGA_RST_N,
    input  logic [1:0]           VGA_MODE,
    input  logic [3*COLOR_W-1:0] VGA_BUF_RGB,
    output logic                 VGA_REQ,
    output logic [CNT_W-1:0]     VGA_X,
    output logic [CNT_W-1:0]     VGA_Y,
    output logic                 VGA_SOF,
    output logic [15:0]          VGA_FRAME_CNT,
    output logic                 VGA_HSYNC,
    output logic                 VGA_VSYNC,
    output logic                 VGA_DE,
    output logic [COLOR_W-1:0]   VGA_R,
    output logic [COLOR_W-1:0]   VGA_G,
    output logic [COLOR_W-1:0]   VGA_B,
    output logic                 VGA_SYNC_N,
    output logic                 VGA_BLANK_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    vga_mode_e            mode_q, mode_d;
    logic                 frame_end, active, hs_act, vs_act;
    logic                 req_p1_q, sof_p1_q, hs_p1_q, vs_p1_q;
    logic [CNT_W-1:0]     x_p1_q, y_p1_q;
    logic                 req_p2_q, hs_p2_q, vs_p2_q;
    logic [3*COLOR_W-1:0] pat_rgb;
    logic                 pat_ext;
    logic                 de_q, hs_q, vs_q;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    always_comb begin
        frame_end = (h_cnt_q == H_LAST_C) && (v_cnt_q == V_LAST_C);
        h_cnt_d   = h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
        end
        // Mode only changes on the frame wrap so a frame never mixes patterns.
        mode_d      = frame_end ? vga_mode_e'(VGA_MODE) : mode_q;
        frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
        active      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_act      = (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
        vs_act      = (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);
        rgb_d       = '0;
        if (req_p2_q) begin
            rgb_d = pat_ext ? VGA_BUF_RGB : pat_rgb;
        end
    end

    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            mode_q      <= MODE_EXT;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
        end
    end

    // Stage 1: request, coordinates and sync levels from the counters.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            req_p1_q <= 1'b0;
            sof_p1_q <= 1'b0;
            x_p1_q   <= '0;
            y_p1_q   <= '0;
            hs_p1_q  <= ~HS_POL;
            vs_p1_q  <= ~VS_POL;
        end else begin
            req_p1_q <= active;
            sof_p1_q <= active && (h_cnt_q == '0) && (v_cnt_q == '0);
            x_p1_q   <= active ? h_cnt_q : '0;
            y_p1_q   <= active ? v_cnt_q : '0;
            hs_p1_q  <= hs_act ? HS_POL : ~HS_POL;
            vs_p1_q  <= vs_act ? VS_POL : ~VS_POL;
        end
    end

    // Stage 2: external buffer answers here; pattern register runs in parallel.
    vga_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W),
        .GRID     (GRID)
    ) u_pattern (
        .clk_i       (VGA_CLK),
        .rst_ni      (VGA_RST_N),
        .req_i       (req_p1_q),
        .x_i         (x_p1_q),
        .y_i         (y_p1_q),
        .mode_i      (mode_q),
        .frame_lsb_i (frame_cnt_q[COLOR_W-1:0]),
        .rgb_o       (pat_rgb),
        .ext_o       (pat_ext)
    );

    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            req_p2_q <= 1'b0;
            hs_p2_q  <= ~HS_POL;
            vs_p2_q  <= ~VS_POL;
        end else begin
            req_p2_q <= req_p1_q;
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
        end
    end

    // Stage 3: output registers; colour is forced to zero outside DE.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
        end else begin
            de_q  <= req_p2_q;
            hs_q  <= hs_p2_q;
            vs_q  <= vs_p2_q;
            rgb_q <= rgb_d;
        end
    end

    assign VGA_REQ       = req_p1_q;
    assign VGA_X         = x_p1_q;
    assign VGA_Y         = y_p1_q;
    assign VGA_SOF       = sof_p1_q;
    assign VGA_FRAME_CNT = frame_cnt_q;
    assign VGA_HSYNC     = hs_q;
    assign VGA_VSYNC     = vs_q;
    assign VGA_DE        = de_q;
    assign VGA_R         = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign VGA_G         = rgb_q[2*COLOR_W-1:COLOR_W];
    assign VGA_B         = rgb_q[COLOR_W-1:0];
    assign VGA_SYNC_N    = 1'b0;
    assign VGA_BLANK_N   = de_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Scoreboard bench: a responder plays frame buffer and queues each request with
// its hand-computed pixel (if listed); a monitor pops and checks on every DE.
`timescale 1ns/1ps
module tb_vga_timing_gen_param;

    // Shrunk timing so several frames fit in a short run.
    localparam int HA = 128, HF = 8, HS = 16, HB = 16;
    localparam int VA = 24, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 168
    localparam int VT = VA + VF + VS + VB;   // 32
    localparam int NV = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst_n = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] buf_rgb = 24'hABCDEF;
    logic        req, sof, hsync, vsync, de, sync_n, blank_n;
    logic [11:0] x, y;
    logic [15:0] fcnt;
    logic [7:0]  r, g, b;

    logic        s_rst_n = 1'b1;
    logic [1:0]  s_mode = 2'd0;
    logic [23:0] s_buf = 24'h123456;
    logic        s_req, s_sof, s_hsync, s_vsync, s_de, s_sync_n, s_blank_n;
    logic [11:0] s_x, s_y;
    logic [15:0] s_fcnt;
    logic [7:0]  s_r, s_g, s_b;

    vga_timing_gen_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .CNT_W(12), .GRID(64)
    ) dut (
        .VGA_CLK(clk), .VGA_RST_N(rst_n), .VGA_MODE(mode), .VGA_BUF_RGB(buf_rgb),
        .VGA_REQ(req), .VGA_X(x), .VGA_Y(y), .VGA_SOF(sof), .VGA_FRAME_CNT(fcnt),
        .VGA_HSYNC(hsync), .VGA_VSYNC(vsync), .VGA_DE(de),
        .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_SYNC_N(sync_n), .VGA_BLANK_N(blank_n)
    );

    vga_timing_gen_param #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(8), .CNT_W(12), .GRID(4)
    ) dut_small (
        .VGA_CLK(clk), .VGA_RST_N(s_rst_n), .VGA_MODE(s_mode), .VGA_BUF_RGB(s_buf),
        .VGA_REQ(s_req), .VGA_X(s_x), .VGA_Y(s_y), .VGA_SOF(s_sof), .VGA_FRAME_CNT(s_fcnt),
        .VGA_HSYNC(s_hsync), .VGA_VSYNC(s_vsync), .VGA_DE(s_de),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_SYNC_N(s_sync_n), .VGA_BLANK_N(s_blank_n)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          frame;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    // Frame 0 external buffer, 1-2 colour bars (16-pixel bars), 3 grid, 4 gradient.
    vec_t vecs [NV] = '{
        '{0,   0,  0, 24'h00005A}, '{0,   5,  3, 24'h05035A}, '{0, 127, 23, 24'h7F175A},
        '{1,   0,  0, 24'hFFFFFF}, '{1,  16,  0, 24'hFFFF00}, '{1,  40,  2, 24'h00FFFF},
        '{1,  50,  3, 24'h00FF00}, '{1,  70,  4, 24'hFF00FF}, '{1,  90,  5, 24'hFF0000},
        '{1, 100,  6, 24'h0000FF}, '{1, 127,  7, 24'h000000}, '{1,  15,  8, 24'hFFFFFF},
        '{2,  16, 20, 24'hFFFF00}, '{2, 100, 15, 24'h0000FF},
        '{3,  64, 10, 24'hFFFFFF}, '{3,  65, 10, 24'h000000}, '{3, 127,  5, 24'hFFFFFF},
        '{3,   5, 23, 24'hFFFFFF}, '{3,   5,  0, 24'hFFFFFF}, '{3,   5,  5, 24'h000000},
        '{3,  63, 10, 24'h000000},
        '{4,  10,  7, 24'h0A0704}, '{4, 127, 23, 24'h7F1704}
    };
    bit hit [NV];

    typedef struct {
        int x;
        int y;
        int frame;
        int cyc;
        int vi;
    } req_t;
    req_t sb_q[$];

    int          frame_idx = -1;
    logic        pend_v = 1'b0;
    logic [23:0] pend_rgb = '0;

    // Frame buffer responder: data for a request appears in the following cycle.
    always @(negedge clk) begin : responder
        req_t e;
        buf_rgb = pend_v ? pend_rgb : 24'hABCDEF;
        pend_v  = req;
        if (req) begin
            if (sof) frame_idx++;
            pend_rgb = {x[7:0], y[7:0], 8'h5A};
            e.x = int'(x);
            e.y = int'(y);
            e.frame = frame_idx;
            e.cyc = cyc;
            e.vi = -1;
            for (int i = 0; i < NV; i++)
                if (vecs[i].frame == frame_idx && vecs[i].x == e.x && vecs[i].y == e.y) e.vi = i;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        req_t e;
        check("sync_n", sync_n, 1'b0);
        if (de) begin
            check("blank_n_active", blank_n, 1'b1);
            check("sb_nonempty_at_de", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("req_to_de_latency", cyc - e.cyc, 2);
                if (e.vi >= 0) begin
                    check($sformatf("rgb_f%0d_x%0d_y%0d", e.frame, e.x, e.y), {r, g, b}, vecs[e.vi].rgb);
                    hit[e.vi] = 1'b1;
                end
            end
        end else begin
            check("blank_n_blank", blank_n, 1'b0);
            check("rgb_blank", {r, g, b}, 24'h0);
        end
    end

    task automatic wait_sof(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req && sof) && n < HT * VT + 20);
        check(tag, req && sof, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, t1, t2, n;
        #2 rst_n = 1'b0;
        s_rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_hsync", hsync, 1'b1);
        check("rst_vsync", vsync, 1'b1);
        check("rst_de", de, 1'b0);
        check("rst_req", req, 1'b0);
        check("rst_sof", sof, 1'b0);
        check("rst_blank_n", blank_n, 1'b0);
        check("rst_rgb", {r, g, b}, 24'h0);
        check("rst_fcnt", fcnt, 16'h0);
        check("rst_xy", {x, y}, 24'h0);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", req, 1'b1);
        check("first_sof", sof, 1'b1);
        check("first_xy", {x, y}, 24'h0);
        t0 = cyc;

        n = 0;
        while (!de && n < 10) begin @(negedge clk); n++; end
        check("first_req_to_de", cyc - t0, 2);
        t1 = cyc;
        n = 0;
        while (de && n < HT) begin @(negedge clk); n++; end
        check("de_run", n, HA);
        t2 = cyc;
        n = 0;
        while (hsync && n < HT) begin @(negedge clk); n++; end
        check("hsync_after_de_fall", cyc - t2, HF);
        n = 0;
        while (!hsync && n < HT) begin @(negedge clk); n++; end
        check("hsync_low_run", n, HS);
        n = 0;
        while (!de && n < HT) begin @(negedge clk); n++; end
        check("line_period", cyc - t1, HT);

        mode = 2'd1;
        n = 0;
        while (vsync && n < HT * VT) begin @(negedge clk); n++; end
        n = 0;
        while (!vsync && n < HT * VT) begin @(negedge clk); n++; end
        check("vsync_low_run", n, VS * HT);
        check("fcnt_frame0", fcnt, 16'd0);

        wait_sof("sof_frame1");
        check("fcnt_frame1", fcnt, 16'd1);
        wait_sof("sof_frame2");
        check("fcnt_frame2", fcnt, 16'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!(req && y == 12'd12) && n < HT * VT);
        check("reach_line12", y, 12'd12);
        mode = 2'd2;
        wait_sof("sof_frame3");
        mode = 2'd3;
        wait_sof("sof_frame4");
        wait_sof("sof_frame5");
        check("fcnt_frame5", fcnt, 16'd5);

        // Small configuration: active-high HSYNC and asynchronous mid-line reset.
        repeat (2) @(negedge clk);
        check("s_rst_hsync", s_hsync, 1'b0);
        check("s_rst_vsync", s_vsync, 1'b1);
        check("s_rst_de", s_de, 1'b0);
        check("s_rst_req", s_req, 1'b0);
        s_rst_n = 1'b1;
        @(negedge clk);
        check("s_first_req", s_req, 1'b1);
        check("s_first_sof", s_sof, 1'b1);
        t0 = cyc;
        n = 0;
        while (s_req && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (!s_req && n < 40) begin @(negedge clk); n++; end
        check("s_line_period", cyc - t0, 23);
        n = 0;
        while (!s_hsync && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (s_hsync && n < 40) begin @(negedge clk); n++; end
        check("s_hsync_high_run", n, 3);
        n = 0;
        while (s_fcnt != 16'd1 && n < 400) begin @(negedge clk); n++; end
        check("s_fcnt_one", s_fcnt, 16'd1);
        n = 0;
        while (!(s_req && s_x == 12'd6) && n < 400) begin @(negedge clk); n++; end
        check("s_de_before_rst", s_de, 1'b1);
        #2 s_rst_n = 1'b0;
        #1;
        check("s_async_req", s_req, 1'b0);
        check("s_async_x", s_x, 12'd0);
        check("s_async_de", s_de, 1'b0);
        check("s_async_hsync", s_hsync, 1'b0);
        check("s_async_vsync", s_vsync, 1'b1);
        check("s_async_fcnt", s_fcnt, 16'd0);
        check("s_async_rgb", {s_r, s_g, s_b}, 24'h0);
        check("s_async_blank_n", s_blank_n, 1'b0);
        @(negedge clk);
        s_rst_n = 1'b1;
        @(negedge clk);
        check("s_restart_req", s_req, 1'b1);
        check("s_restart_sof", s_sof, 1'b1);
        check("s_restart_xy", {s_x, s_y}, 24'h0);

        for (int i = 0; i < NV; i++) check($sformatf("vec%0d_seen", i), hit[i], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
